// File: rtl/jam_pkg.sv
// ============================================================================
// Module  : jam_pkg
// Brief   : Shared widths, FSM state type and helpers for the JAM cost table.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jam_pkg;

    localparam int N           = 8;
    localparam int IDX_W       = 3;
    localparam int COST_W      = 7;
    localparam int QCNT_W      = 16;
    localparam int ADDR_W      = 2 * IDX_W;
    localparam int HOLD_CYCLES = 2;
    localparam int HCNT_W      = 2;
    localparam int MC_W        = 4;
    localparam int MINC_W      = 10;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);
    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_CYCLES - 1);
    localparam logic [QCNT_W-1:0] QCNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SERVE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [QCNT_W-1:0] qcnt_sat_inc(input logic [QCNT_W-1:0] v);
        return (v == QCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jam_cost_mem.sv
// ============================================================================
// Module  : jam_cost_mem
// Brief   : N*N cost register array; synchronous write, asynchronous read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jam_cost_mem
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [IDX_W-1:0]  rw,
    input  logic [IDX_W-1:0]  rj,
    output logic [COST_W-1:0] rdata
);

    // No reset: contents persist across RST and are simply overwritten on reload.
    logic [COST_W-1:0] mem_q [N*N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[{rw, rj}];

endmodule

`default_nettype wire

// File: rtl/jam_cost_table.sv
// ============================================================================
// Module  : jam_cost_table
// Brief   : Responder side of the JAM cost interface: loads the cost matrix,
//           serves (W,J) lookups, holds JAM in reset and captures its result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jam_cost_table
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              ld_valid,
    input  logic [COST_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              jam_rst,
    input  logic [IDX_W-1:0]  W,
    input  logic [IDX_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [MC_W-1:0]   MatchCount,
    input  logic [MINC_W-1:0] MinCost,
    output logic              done,
    output logic [MC_W-1:0]   res_match_count,
    output logic [MINC_W-1:0] res_min_cost,
    output logic [QCNT_W-1:0] query_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [HCNT_W-1:0]   hold_q, hold_d;
    logic [QCNT_W-1:0]   qcnt_q, qcnt_d;
    logic [ADDR_W-1:0]   prev_q, prev_d;
    logic [MC_W-1:0]     res_mc_q, res_mc_d;
    logic [MINC_W-1:0]   res_min_q, res_min_d;

    logic                w_xfer;
    logic [COST_W-1:0]   w_rdata;
    logic [ADDR_W-1:0]   w_wj;

    assign w_xfer = ld_valid && (state_q == ST_LOAD);
    assign w_wj   = {W, J};

    jam_cost_mem u_mem (
        .clk   (CLK),
        .we    (w_xfer),
        .waddr (addr_q),
        .wdata (ld_data),
        .rw    (W),
        .rj    (J),
        .rdata (w_rdata)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        qcnt_d    = qcnt_q;
        prev_d    = prev_q;
        res_mc_d  = res_mc_q;
        res_min_d = res_min_q;

        case (state_q)
            ST_LOAD: begin
                if (w_xfer) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_SERVE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_SERVE: begin
                prev_d = w_wj;
                if (w_wj != prev_q) begin
                    qcnt_d = qcnt_sat_inc(qcnt_q);
                end
                // JAM's Valid is unreset until it has issued at least one query.
                if (Valid && (qcnt_q != '0)) begin
                    res_mc_d  = MatchCount;
                    res_min_d = MinCost;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_LOAD;
            addr_q    <= '0;
            hold_q    <= '0;
            qcnt_q    <= '0;
            prev_q    <= '0;
            res_mc_q  <= '0;
            res_min_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            qcnt_q    <= qcnt_d;
            prev_q    <= prev_d;
            res_mc_q  <= res_mc_d;
            res_min_q <= res_min_d;
        end
    end

    assign ld_ready        = (state_q == ST_LOAD);
    assign jam_rst         = (state_q == ST_LOAD) || (state_q == ST_HOLD);
    assign done            = (state_q == ST_DONE);
    assign Cost            = jam_rst ? '0 : w_rdata;
    assign res_match_count = res_mc_q;
    assign res_min_cost    = res_min_q;
    assign query_count     = qcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_table.sv
// ============================================================================
// Module  : tb_jam_cost_table
// Brief   : Directed self-checking bench for jam_cost_table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jam_cost_table;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ld_valid = 1'b0;
    logic [6:0]  ld_data = '0;
    logic        ld_ready;
    logic        jam_rst;
    logic [2:0]  W = '0;
    logic [2:0]  J = '0;
    logic [6:0]  Cost;
    logic        Valid = 1'b0;
    logic [3:0]  MatchCount = '0;
    logic [9:0]  MinCost = '0;
    logic        done;
    logic [3:0]  res_match_count;
    logic [9:0]  res_min_cost;
    logic [15:0] query_count;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    jam_cost_table dut (
        .CLK             (CLK),
        .RST             (RST),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .jam_rst         (jam_rst),
        .W               (W),
        .J               (J),
        .Cost            (Cost),
        .Valid           (Valid),
        .MatchCount      (MatchCount),
        .MinCost         (MinCost),
        .done            (done),
        .res_match_count (res_match_count),
        .res_min_cost    (res_min_cost),
        .query_count     (query_count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; ld_valid = 1'b0; Valid = 1'b0;
        W = '0; J = '0; MatchCount = '0; MinCost = '0;
        tick(); tick();
        RST = 1'b0;
    endtask

    // Streams entries until nmax transfers; entry value is its index or 0x7F.
    task automatic load_table(input bit all7f, input bit gaps, input int nmax,
                              output int transfers, output int cycles);
        bit v;
        bit acc;
        transfers = 0;
        cycles    = 0;
        while (transfers < nmax && cycles < 400) begin
            v        = gaps ? (cycles % 2 == 0) : 1'b1;
            ld_valid = v;
            ld_data  = all7f ? 7'h7F : 7'(transfers);
            acc      = v && ld_ready;
            tick();
            if (acc) transfers++;
            cycles++;
        end
        ld_valid = 1'b0;
    endtask

    task automatic wait_serve(output int c);
        c = 0;
        while (jam_rst !== 1'b0 && c < 10) begin
            tick();
            c++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready got=%0b exp=1", ld_ready); end
        checks++; if (jam_rst !== 1'b1) begin failures++; $display("FAIL reset_jam_rst got=%0b exp=1", jam_rst); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if ({res_match_count, res_min_cost} !== 14'd0) begin failures++; $display("FAIL reset_res got=%0d/%0d exp=0/0", res_match_count, res_min_cost); end
        checks++; if (query_count !== 16'd0) begin failures++; $display("FAIL reset_qcnt got=%0d exp=0", query_count); end
        checks++; if (Cost !== 7'd0) begin failures++; $display("FAIL reset_cost got=%0d exp=0", Cost); end
    endtask

    task automatic test_load_no_gaps();
        int t, c;
        do_reset();
        load_table(1'b0, 1'b0, 64, t, c);
        checks++; if (t !== 64 || c !== 64) begin failures++; $display("FAIL nogap_xfers got=%0d/%0d exp=64/64", t, c); end
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL nogap_ready_drop got=%0b exp=0", ld_ready); end
        checks++; if (jam_rst !== 1'b1) begin failures++; $display("FAIL nogap_hold1 got=%0b exp=1", jam_rst); end
        tick();
        checks++; if (jam_rst !== 1'b1) begin failures++; $display("FAIL nogap_hold2 got=%0b exp=1", jam_rst); end
        tick();
        checks++; if (jam_rst !== 1'b0) begin failures++; $display("FAIL nogap_serve got=%0b exp=0", jam_rst); end
        W = 3'd3; J = 3'd5; #1;
        checks++; if (Cost !== 7'd29) begin failures++; $display("FAIL nogap_cost35 got=%0d exp=29", Cost); end
    endtask

    task automatic test_load_gapped();
        int t, c;
        do_reset();
        load_table(1'b0, 1'b1, 64, t, c);
        checks++; if (t !== 64 || c !== 127) begin failures++; $display("FAIL gap_xfers got=%0d/%0d exp=64/127", t, c); end
        ld_valid = 1'b1; ld_data = 7'h55;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL gap_hold_ready got=%0b exp=0", ld_ready); end
        tick();
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL gap_hold_ready2 got=%0b exp=0", ld_ready); end
        tick();
        ld_valid = 1'b0;
        checks++; if (jam_rst !== 1'b0) begin failures++; $display("FAIL gap_serve got=%0b exp=0", jam_rst); end
        W = 3'd7; J = 3'd7; #1;
        checks++; if (Cost !== 7'd63) begin failures++; $display("FAIL gap_cost77 got=%0d exp=63", Cost); end
        W = 3'd1; J = 3'd6; #1;
        checks++; if (Cost !== 7'd14) begin failures++; $display("FAIL gap_cost16 got=%0d exp=14", Cost); end
    endtask

    task automatic test_reset_midload();
        int t, c;
        do_reset();
        load_table(1'b1, 1'b0, 30, t, c);
        W = 3'd3; J = 3'd5; #1;
        checks++; if (Cost !== 7'd0) begin failures++; $display("FAIL midload_cost_forced got=%0d exp=0", Cost); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (ld_ready !== 1'b1 || jam_rst !== 1'b1) begin failures++; $display("FAIL midload_rst got=%0b/%0b exp=1/1", ld_ready, jam_rst); end
        load_table(1'b1, 1'b0, 64, t, c);
        checks++; if (t !== 64 || c !== 64) begin failures++; $display("FAIL midload_reload got=%0d/%0d exp=64/64", t, c); end
        wait_serve(c);
        checks++; if (c !== 2) begin failures++; $display("FAIL midload_hold_len got=%0d exp=2", c); end
        W = 3'd0; J = 3'd0; #1;
        checks++; if (Cost !== 7'd127) begin failures++; $display("FAIL midload_cost00 got=%0d exp=127", Cost); end
        W = 3'd3; J = 3'd5; #1;
        checks++; if (Cost !== 7'd127) begin failures++; $display("FAIL midload_cost35 got=%0d exp=127", Cost); end
        W = 3'd7; J = 3'd7; #1;
        checks++; if (Cost !== 7'd127) begin failures++; $display("FAIL midload_cost77 got=%0d exp=127", Cost); end
    endtask

    task automatic test_query_count();
        int t, c;
        logic [2:0]  wv [5];
        logic [2:0]  jv [5];
        logic [15:0] ev [5];
        wv = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2};
        jv = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd4};
        ev = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd2};
        do_reset();
        load_table(1'b0, 1'b0, 64, t, c);
        wait_serve(c);
        for (int i = 0; i < 5; i++) begin
            W = wv[i]; J = jv[i]; #1;
            if (i == 3) begin
                checks++; if (Cost !== 7'd20) begin failures++; $display("FAIL query_cost24 got=%0d exp=20", Cost); end
            end
            tick();
            checks++; if (query_count !== ev[i]) begin failures++; $display("FAIL query_count step=%0d got=%0d exp=%0d", i, query_count, ev[i]); end
        end
    endtask

    task automatic test_capture();
        Valid = 1'b1; MatchCount = 4'd4; MinCost = 10'd100;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL cap_done got=%0b exp=1", done); end
        checks++; if (res_match_count !== 4'd4 || res_min_cost !== 10'd100) begin failures++; $display("FAIL cap_res got=%0d/%0d exp=4/100", res_match_count, res_min_cost); end
        MatchCount = 4'd9; MinCost = 10'd555; W = 3'd1; J = 3'd2;
        tick();
        Valid = 1'b0; W = 3'd5;
        tick();
        Valid = 1'b1; J = 3'd0;
        tick();
        W = 3'd1; J = 3'd2; #1;
        checks++; if (res_match_count !== 4'd4 || res_min_cost !== 10'd100) begin failures++; $display("FAIL cap_frozen got=%0d/%0d exp=4/100", res_match_count, res_min_cost); end
        checks++; if (query_count !== 16'd2) begin failures++; $display("FAIL cap_qcnt_frozen got=%0d exp=2", query_count); end
        checks++; if (done !== 1'b1 || jam_rst !== 1'b0) begin failures++; $display("FAIL cap_done_state got=%0b/%0b exp=1/0", done, jam_rst); end
        checks++; if (Cost !== 7'd10) begin failures++; $display("FAIL cap_cost12 got=%0d exp=10", Cost); end
        Valid = 1'b0;
    endtask

    task automatic test_valid_first_cycle();
        int t, c;
        do_reset();
        load_table(1'b0, 1'b0, 64, t, c);
        wait_serve(c);
        Valid = 1'b1; MatchCount = 4'd3; MinCost = 10'd77;
        tick();
        checks++; if (done !== 1'b0 || query_count !== 16'd0) begin failures++; $display("FAIL first_valid got done=%0b qcnt=%0d exp=0/0", done, query_count); end
        W = 3'd1;
        tick();
        checks++; if (done !== 1'b0 || query_count !== 16'd1) begin failures++; $display("FAIL first_query got done=%0b qcnt=%0d exp=0/1", done, query_count); end
        W = 3'd2;
        tick();
        checks++; if (done !== 1'b1 || query_count !== 16'd2) begin failures++; $display("FAIL simul_cap got done=%0b qcnt=%0d exp=1/2", done, query_count); end
        checks++; if (res_match_count !== 4'd3 || res_min_cost !== 10'd77) begin failures++; $display("FAIL simul_res got=%0d/%0d exp=3/77", res_match_count, res_min_cost); end
        W = 3'd4;
        tick();
        checks++; if (query_count !== 16'd2) begin failures++; $display("FAIL simul_frozen got=%0d exp=2", query_count); end
        Valid = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_load_no_gaps();
        test_load_gapped();
        test_reset_midload();
        test_query_count();
        test_capture();
        test_valid_first_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
